parking_fee_collector: RTL and testbench
========================================

# parking_fee_collector

Payment stage downstream of the parking controller: it latches the fee the controller presents on its `data_P` output, collects coins until the fee is covered, then returns change and opens the exit gate for a fixed number of cycles. It also handles cancel and inactivity timeout, refunding everything inserted in both cases. Single clock domain, fully registered outputs.

## Interface
- GATE_CYCLES, 8: cycles `gate_open` stays high after payment (≥1).
- TIMEOUT_CYCLES, 255: consecutive coin-free cycles in COLLECT before abort (≥2, ≤65535).

- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low; sampled on rising edge of clock.
- fee_valid  input  1  one-cycle strobe: `fee` is valid.
- fee  input  8  amount due, unsigned units (driven from controller `data_P`).
- coin_valid  input  1  one-cycle strobe per inserted coin.
- coin_value  input  2  00=1, 01=2, 10=5, 11=10 units.
- cancel  input  1  user abort, level sampled each cycle.
- busy  output  1  high in COLLECT and OPEN.
- remaining  output  8  amount still due.
- paid  output  1  one-cycle pulse on payment completion.
- change  output  8  overpayment of the last completed transaction.
- refund  output  8  amount returned by the last cancel/timeout.
- gate_open  output  1  exit gate drive.
- timeout  output  1  one-cycle pulse on inactivity abort.

## Operation
- States: IDLE, COLLECT, OPEN (2-bit encoding).
- Internal: `inserted` 8-bit running sum; `idle_cnt` 16-bit; `gate_cnt` sized for GATE_CYCLES.
- IDLE, fee_valid=1, fee≠0: remaining←fee, inserted←0, change←0, refund←0, idle_cnt←0 → COLLECT.
- IDLE, fee_valid=1, fee=0: change←0, refund←0, paid pulse → OPEN.
- fee_valid is ignored outside IDLE; coin_valid and cancel are ignored outside COLLECT.
- COLLECT priority, highest first: cancel, coin, timeout.
  - cancel=1: refund←inserted, remaining←0 → IDLE. A coin in the same cycle is discarded and not counted.
  - coin_valid, v≥remaining: change←v−remaining, remaining←0, paid pulse → OPEN.
  - coin_valid, v<remaining: remaining←remaining−v, inserted←inserted+v, idle_cnt←0.
  - no coin: idle_cnt increments. At idle_cnt=TIMEOUT_CYCLES−1, instead: timeout pulse, refund←inserted, remaining←0 → IDLE.
- Width rules:
  - `inserted` never exceeds fee−1, so it fits 8 bits.
  - change ≤ 9.
  - Subtraction happens only when v<remaining, so no wrap.
- OPEN: gate_open=1, gate_cnt counts GATE_CYCLES cycles, then → IDLE with gate_open=0.
- change and refund hold until the next accepted fee.

## Timing
- Reset (reset=0 at edge): state=IDLE; busy, paid, timeout, gate_open = 0; remaining, change, refund = 0; all counters 0. Reset mid-transaction discards the transaction with no refund reported.
- Fee accepted at edge k: busy=1 and remaining=fee from cycle k+1.
- Final coin at edge k: paid=1 for cycle k+1 only; gate_open=1 for cycles k+1 .. k+GATE_CYCLES; busy=0 and state=IDLE from k+GATE_CYCLES+1.
- fee=0 accepted at edge k: same as final coin at edge k.
- A new fee_valid is accepted at the first edge where state=IDLE, i.e. the cycle after gate_open falls.
- Timeout: with the last coin or entry at edge k and no coin after, timeout=1 for cycle k+TIMEOUT_CYCLES+1 and busy=0 from that cycle.
- Cancel at edge k: busy=0 and refund valid from cycle k+1.
- Back-to-back coins on consecutive cycles are all counted.

## Test plan
- Reset held low 3 cycles then released → all outputs 0, state IDLE; fee_valid with fee=20 → remaining=20, busy=1 next cycle.
- fee=20; coins 10, 5, 5 on consecutive cycles → remaining 10, 5, 0; paid one cycle; change=0; gate_open exactly 8 cycles; busy drops the cycle after.
- fee=7; coins 5, 5 → remaining 2 then paid; change=3; a fee_valid pulse (fee=9) during OPEN is ignored, remaining stays 0.
- fee=30; coins 10, 2; cancel asserted together with a coin_value=10 coin → refund=12, coin discarded, paid never asserts, gate_open stays 0.
- TIMEOUT_CYCLES=16, fee=50; one coin 5, then idle → timeout pulses exactly 16 cycles after the coin edge; refund=5; busy=0.
- fee=0 → immediate paid pulse and gate_open for GATE_CYCLES; separately, reset asserted mid-COLLECT (fee=40, 10 inserted) → all outputs 0 next cycle, refund=0.

Source files
------------

// File: rtl/parking_fee_collector.sv
// Payment stage behind the parking controller: latches the fee, collects coins,
// returns change and opens the gate; refunds on cancel or inactivity timeout.
module parking_fee_collector #(
    parameter int GATE_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       fee_valid,
    input  logic [7:0] fee,
    input  logic       coin_valid,
    input  logic [1:0] coin_value,
    input  logic       cancel,
    output logic       busy,
    output logic [7:0] remaining,
    output logic       paid,
    output logic [7:0] change,
    output logic [7:0] refund,
    output logic       gate_open,
    output logic       timeout
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [15:0]   IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OPEN    = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [7:0]    remaining_n, inserted, inserted_n, change_n, refund_n, coin_v;
    logic [15:0]   idle_cnt, idle_cnt_n;
    logic [GW-1:0] gate_cnt, gate_cnt_n;
    logic          paid_n, timeout_n;

    function automatic logic [7:0] coin_units(input logic [1:0] code);
        case (code)
            2'b00:   return 8'd1;
            2'b01:   return 8'd2;
            2'b10:   return 8'd5;
            default: return 8'd10;
        endcase
    endfunction

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        inserted_n  = inserted;
        change_n    = change;
        refund_n    = refund;
        idle_cnt_n  = idle_cnt;
        gate_cnt_n  = gate_cnt;
        paid_n      = 1'b0;
        timeout_n   = 1'b0;
        coin_v      = coin_units(coin_value);
        case (state)
            IDLE: begin
                if (fee_valid) begin
                    change_n = 8'd0;
                    refund_n = 8'd0;
                    if (fee != 8'd0) begin
                        remaining_n = fee;
                        inserted_n  = 8'd0;
                        idle_cnt_n  = 16'd0;
                        state_n     = COLLECT;
                    end else begin
                        paid_n     = 1'b1;
                        gate_cnt_n = '0;
                        state_n    = OPEN;
                    end
                end
            end
            COLLECT: begin
                // Cancel wins over a coin arriving in the same cycle; that coin is dropped.
                if (cancel) begin
                    refund_n    = inserted;
                    remaining_n = 8'd0;
                    state_n     = IDLE;
                end else if (coin_valid) begin
                    if (coin_v >= remaining) begin
                        change_n    = coin_v - remaining;
                        remaining_n = 8'd0;
                        paid_n      = 1'b1;
                        gate_cnt_n  = '0;
                        state_n     = OPEN;
                    end else begin
                        remaining_n = remaining - coin_v;
                        inserted_n  = inserted + coin_v;
                        idle_cnt_n  = 16'd0;
                    end
                end else if (idle_cnt == IDLE_LAST) begin
                    timeout_n   = 1'b1;
                    refund_n    = inserted;
                    remaining_n = 8'd0;
                    state_n     = IDLE;
                end else begin
                    idle_cnt_n = idle_cnt + 16'd1;
                end
            end
            OPEN: begin
                if (gate_cnt == GATE_LAST) begin
                    gate_cnt_n = '0;
                    state_n    = IDLE;
                end else begin
                    gate_cnt_n = gate_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they change with the state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= 8'd0;
            inserted  <= 8'd0;
            change    <= 8'd0;
            refund    <= 8'd0;
            idle_cnt  <= 16'd0;
            gate_cnt  <= '0;
            paid      <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
            gate_open <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            inserted  <= inserted_n;
            change    <= change_n;
            refund    <= refund_n;
            idle_cnt  <= idle_cnt_n;
            gate_cnt  <= gate_cnt_n;
            paid      <= paid_n;
            timeout   <= timeout_n;
            busy      <= (state_n != IDLE);
            gate_open <= (state_n == OPEN);
        end
    end

endmodule

// File: tb/tb_parking_fee_collector.sv
// Self-checking bench for parking_fee_collector: hand-derived vector table,
// directed corner sequences, and randomized traffic against a behavioural model.
module tb_parking_fee_collector;

    localparam int G = 8;
    localparam int T = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       fee_valid = 1'b0;
    logic [7:0] fee = 8'd0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_value = 2'd0;
    logic       cancel = 1'b0;
    logic       busy, paid, gate_open, timeout;
    logic [7:0] remaining, change, refund;

    always #5 clock = ~clock;

    parking_fee_collector #(.GATE_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset), .fee_valid(fee_valid), .fee(fee),
        .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel),
        .busy(busy), .remaining(remaining), .paid(paid), .change(change),
        .refund(refund), .gate_open(gate_open), .timeout(timeout)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: mode 0 idle, 1 paying, 2 gate up.
    int coin_tab [4] = '{1, 2, 5, 10};
    int m_mode = 0, m_due = 0, m_sum = 0, m_quiet = 0, m_gate_left = 0;
    int m_change = 0, m_refund = 0;
    bit m_paid = 0, m_to = 0;

    task automatic model_edge();
        int v;
        m_paid = 0;
        m_to   = 0;
        if (!reset) begin
            m_mode = 0; m_due = 0; m_sum = 0; m_quiet = 0; m_gate_left = 0;
            m_change = 0; m_refund = 0;
        end else if (m_mode == 0) begin
            if (fee_valid) begin
                m_change = 0;
                m_refund = 0;
                if (fee == 0) begin
                    m_paid = 1; m_mode = 2; m_gate_left = G;
                end else begin
                    m_due = fee; m_sum = 0; m_quiet = 0; m_mode = 1;
                end
            end
        end else if (m_mode == 1) begin
            v = coin_tab[coin_value];
            if (cancel) begin
                m_refund = m_sum; m_due = 0; m_mode = 0;
            end else if (coin_valid) begin
                if (v >= m_due) begin
                    m_change = v - m_due; m_due = 0; m_paid = 1;
                    m_mode = 2; m_gate_left = G;
                end else begin
                    m_due -= v; m_sum += v; m_quiet = 0;
                end
            end else begin
                m_quiet++;
                if (m_quiet == T) begin
                    m_to = 1; m_refund = m_sum; m_due = 0; m_mode = 0;
                end
            end
        end else begin
            m_gate_left--;
            if (m_gate_left == 0) m_mode = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, exp);
        end
    endtask

    task automatic check_model();
        check("m_busy",      32'(busy),      32'(m_mode != 0));
        check("m_remaining", 32'(remaining), 32'(m_due));
        check("m_paid",      32'(paid),      32'(m_paid));
        check("m_change",    32'(change),    32'(m_change));
        check("m_refund",    32'(refund),    32'(m_refund));
        check("m_gate",      32'(gate_open), 32'(m_mode == 2));
        check("m_timeout",   32'(timeout),   32'(m_to));
    endtask

    task automatic cycle(input logic r, input logic fv, input logic [7:0] f,
                         input logic cv, input logic [1:0] cval, input logic cn);
        reset = r; fee_valid = fv; fee = f; coin_valid = cv; coin_value = cval; cancel = cn;
        @(posedge clock);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic idle1();
        cycle(1'b1, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0);
    endtask

    typedef struct {
        logic       r, fv;
        logic [7:0] f;
        logic       cv;
        logic [1:0] cval;
        logic       cn;
        logic       e_busy;
        logic [7:0] e_rem;
        logic       e_paid;
        logic [7:0] e_chg, e_rfd;
        logic       e_gate, e_to;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic fv, input logic [7:0] f, input logic cv,
                       input logic [1:0] cval, input logic cn, input logic b, input logic [7:0] rem,
                       input logic p, input logic [7:0] chg, input logic [7:0] rfd,
                       input logic g, input logic to);
        vec_t v;
        v = '{r, fv, f, cv, cval, cn, b, rem, p, chg, rfd, g, to};
        tbl.push_back(v);
    endtask

    initial begin
        int cnt;
        bit done;
        // reset, then fee=20 paid with 10,5,5
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        add(1, 1, 20, 0, 0, 0, 1, 20, 0, 0, 0, 0, 0);
        add(1, 0, 0,  1, 3, 0, 1, 10, 0, 0, 0, 0, 0);
        add(1, 0, 0,  1, 2, 0, 1, 5,  0, 0, 0, 0, 0);
        add(1, 0, 0,  1, 2, 0, 1, 0,  1, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        // fee=7 paid with 5,5 -> change 3; fee pulse during OPEN ignored
        add(1, 1, 7,  0, 0, 0, 1, 7,  0, 0, 0, 0, 0);
        add(1, 0, 0,  1, 2, 0, 1, 2,  0, 0, 0, 0, 0);
        add(1, 0, 0,  1, 2, 0, 1, 0,  1, 3, 0, 1, 0);
        add(1, 1, 9,  0, 0, 0, 1, 0,  0, 3, 0, 1, 0);
        for (int i = 0; i < 6; i++) add(1, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 1, 0);
        add(1, 0, 0,  0, 0, 0, 0, 0,  0, 3, 0, 0, 0);
        // fee=30, coins 10,2, then cancel with a 10 coin that must be dropped
        add(1, 1, 30, 0, 0, 0, 1, 30, 0, 0, 0,  0, 0);
        add(1, 0, 0,  1, 3, 0, 1, 20, 0, 0, 0,  0, 0);
        add(1, 0, 0,  1, 1, 0, 1, 18, 0, 0, 0,  0, 0);
        add(1, 0, 0,  1, 3, 1, 0, 0,  0, 0, 12, 0, 0);
        add(1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 12, 0, 0);

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].fv, tbl[i].f, tbl[i].cv, tbl[i].cval, tbl[i].cn);
            check($sformatf("row%0d", i),
                  32'({busy, remaining, paid, change, refund, gate_open, timeout}),
                  32'({tbl[i].e_busy, tbl[i].e_rem, tbl[i].e_paid, tbl[i].e_chg,
                       tbl[i].e_rfd, tbl[i].e_gate, tbl[i].e_to}));
        end

        // inactivity timeout: fee=50, one 5 coin, then silence
        cycle(1, 1, 50, 0, 0, 0);
        check("to_busy", 32'(busy), 32'd1);
        cycle(1, 0, 0, 1, 2, 0);
        for (int i = 1; i < T; i++) begin
            idle1();
            check("to_early", 32'(timeout), 32'd0);
        end
        idle1();
        check("to_pulse", 32'({timeout, busy, refund}), 32'({1'b1, 1'b0, 8'd5}));
        idle1();
        check("to_clear", 32'(timeout), 32'd0);

        // fee=0: immediate payment and a gate window of G cycles
        cycle(1, 1, 0, 0, 0, 0);
        check("fee0_paid", 32'({paid, gate_open}), 32'({1'b1, 1'b1}));
        cnt = 1;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            idle1();
            if (gate_open) cnt++;
            else done = 1;
        end
        check("gate_len", 32'(cnt), 32'(G));
        check("gate_busy", 32'(busy), 32'd0);

        // reset in the middle of collecting drops the transaction silently
        cycle(1, 1, 40, 0, 0, 0);
        cycle(1, 0, 0, 1, 3, 0);
        check("mid_rem", 32'(remaining), 32'd30);
        cycle(0, 0, 0, 0, 0, 0);
        check("mid_rst", 32'({busy, remaining, refund, change, gate_open}), 32'd0);
        idle1();

        // randomized traffic, alternating busy and sparse coin phases
        for (int i = 0; i < 4000; i++) begin
            logic r, fv, cv, cn;
            logic [7:0] f;
            r  = ($urandom_range(0, 499) != 0);
            fv = ($urandom_range(0, 5) == 0);
            f  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 60));
            cv = ((i / 500) % 2 == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 24) == 0);
            cn = ($urandom_range(0, 59) == 0);
            cycle(r, fv, f, cv, 2'($urandom_range(0, 3)), cn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
